mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data and address width.
REQ-002 Parameter STARVE_MAX, default 3, maximum consecutive data grants while a fetch is pending.
REQ-003 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, asynchronous, active-low reset.
REQ-005 Port if_req, input, 1, instruction-fetch read request.
REQ-006 Port if_addr, input, XLEN, fetch byte address.
REQ-007 Port if_gnt, output, 1, fetch request accepted this cycle.
REQ-008 Port if_rvalid / if_rdata, output, 1 / XLEN, fetch data valid / fetch data.
REQ-009 Port dm_req / dm_we, input, 1 / 1, data-stage request / write enable.
REQ-010 Port dm_addr / dm_wdata, input, XLEN / XLEN, data byte address / store data.
REQ-011 Port dm_gnt, output, 1, data request accepted this cycle.
REQ-012 Port dm_rvalid / dm_rdata, output, 1 / XLEN, load data valid / load data.
REQ-013 Port dm_err, output, 1, one-cycle pulse: the data request was misaligned and rejected.
REQ-014 Port mem_en / mem_we, output, 1 / 1, shared single-port memory enable / write.
REQ-015 Port mem_addr / mem_wdata / mem_rdata, out / out / in, XLEN each, memory address, write data, read data (memory read latency exactly 1 cycle).

Function
REQ-016 At most one of if_gnt, dm_gnt SHALL be high in any cycle; grant is combinational from the requests and registered arbiter state, in the same cycle as the request.
REQ-017 Default priority SHALL be data over fetch.
REQ-018 Starvation counter SHALL increment on each dm_gnt while if_req is high, and clear on if_gnt or whenever if_req is low.
REQ-019 When the counter equals STARVE_MAX and if_req is high, if_gnt SHALL win over dm_req.
REQ-020 mem_en SHALL equal if_gnt OR dm_gnt; mem_addr, mem_we, and mem_wdata SHALL come from the granted requester; when idle, mem_addr and mem_wdata are 0 and mem_we is 0.
REQ-021 A misaligned data request (dm_addr[1:0] != 0) SHALL NOT be granted or drive the memory, SHALL pulse dm_err for 1 cycle after the request cycle, and SHALL leave the fetch free to take that cycle.
REQ-022 Read latency: rvalid SHALL be asserted exactly one cycle after a read grant, with rdata equal to mem_rdata, routed by a registered owner tag (NONE / IF / DM).
REQ-023 A write grant SHALL produce no rvalid; it completes in the grant cycle.
REQ-024 Back-to-back grants SHALL be allowed every cycle; a read grant and the previous grant's rvalid may coincide.
REQ-025 When an rvalid is not asserted, the corresponding rdata SHALL be 0.
REQ-026 With both requests low, the owner tag SHALL go to NONE and no rvalid is issued in the next cycle.

Reset
REQ-027 While reset is low, all of the following SHALL hold: if_gnt, dm_gnt, if_rvalid, dm_rvalid, dm_err, mem_en, and mem_we are 0; the counter is 0; the owner tag is NONE.
REQ-028 A read granted in the cycle reset asserts SHALL be discarded; no rvalid appears after reset release.
REQ-029 The first grant SHALL be possible in the first rising edge cycle after reset deasserts.

Structure
REQ-030 The shared package SHALL hold XLEN and the owner-tag enum (OWN_NONE, OWN_IF, OWN_DM).
REQ-031 The starvation counter SHALL be one sub-module, arb_starve_cnt (inputs: inc, clr; output: at_max); everything else stays in mem_arbiter.

Verification
REQ-032 Scenario: only if_req, with if_addr=0x10 and mem_rdata=0xDEADBEEF. Required: if_gnt in the same cycle; if_rvalid=1 and if_rdata=0xDEADBEEF the next cycle.
REQ-033 Scenario: if_req and dm_req (load, dm_addr=0x100) in the same cycle. Required: dm_gnt=1 and if_gnt=0; dm_rvalid the next cycle; if_gnt the following cycle once dm_req drops.
REQ-034 Scenario: if_req and dm_req held high for 8 cycles with STARVE_MAX=3. Required grant pattern: DM, DM, DM, IF, DM, DM, DM, IF.
REQ-035 Scenario: dm store with dm_addr=0x102. Required: no dm_gnt, mem_en=0, dm_err pulses once the next cycle, and a concurrent if_req is granted.
REQ-036 Scenario: reset driven low in the same cycle as a dm read grant. Required: all outputs 0 immediately (asynchronous); no dm_rvalid after release.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter: default bus width and
// the owner tag that routes read data back to the requester granted last cycle.
package mem_arbiter_pkg;
    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and shared memory port around the arbiter.
// The slave view is the arbiter; the master view is the requesters plus memory.
interface mem_arbiter_if #(
    parameter int XLEN = mem_arbiter_pkg::XLEN
);
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_gnt;
    logic            if_rvalid;
    logic [XLEN-1:0] if_rdata;

    logic            dm_req;
    logic            dm_we;
    logic [XLEN-1:0] dm_addr;
    logic [XLEN-1:0] dm_wdata;
    logic            dm_gnt;
    logic            dm_rvalid;
    logic [XLEN-1:0] dm_rdata;
    logic            dm_err;

    logic            mem_en;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, dm_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, dm_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter_starve_cnt.sv
// Counts data grants taken while a fetch waits; at_max tells the arbiter to
// hand the next cycle to the fetch.
module arb_starve_cnt #(
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);
    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] MAXV = CW'(STARVE_MAX);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAXV)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_max = (cnt == MAXV);
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port, 1-cycle-latency memory between instruction fetch
// and the data stage: data first, with a starvation guard for the fetch.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int XLEN       = mem_arbiter_pkg::XLEN,
    parameter int STARVE_MAX = 3
) (
    input  logic            clk,
    input  logic            reset,
    mem_arbiter_if.slave    bus
);
    localparam logic [XLEN-1:0] ZERO = '0;

    owner_e owner_q, owner_d;
    logic   err_q, err_d;
    logic   dm_ok, at_max, if_win, dm_win;

    // Grant decision is purely combinational; reset forces both grants low.
    assign dm_ok  = bus.dm_req && (bus.dm_addr[1:0] == 2'b00);
    assign if_win = reset && bus.if_req && (!dm_ok || at_max);
    assign dm_win = reset && dm_ok && !(bus.if_req && at_max);

    arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk    (clk),
        .reset  (reset),
        .inc    (dm_win && bus.if_req),
        .clr    (if_win || !bus.if_req),
        .at_max (at_max)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q <= OWN_NONE;
            err_q   <= 1'b0;
        end else begin
            owner_q <= owner_d;
            err_q   <= err_d;
        end
    end

    // Writes finish in the grant cycle, so only reads claim the return slot.
    always_comb begin
        owner_d = OWN_NONE;
        if (if_win) begin
            owner_d = OWN_IF;
        end else if (dm_win && !bus.dm_we) begin
            owner_d = OWN_DM;
        end
        err_d = bus.dm_req && (bus.dm_addr[1:0] != 2'b00);
    end

    always_comb begin
        bus.if_gnt    = if_win;
        bus.dm_gnt    = dm_win;
        bus.mem_en    = if_win || dm_win;
        bus.mem_we    = dm_win && bus.dm_we;
        bus.mem_addr  = ZERO;
        bus.mem_wdata = ZERO;
        if (if_win) begin
            bus.mem_addr = bus.if_addr;
        end else if (dm_win) begin
            bus.mem_addr  = bus.dm_addr;
            bus.mem_wdata = bus.dm_wdata;
        end
        bus.if_rvalid = (owner_q == OWN_IF);
        bus.dm_rvalid = (owner_q == OWN_DM);
        bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : ZERO;
        bus.dm_rdata  = bus.dm_rvalid ? bus.mem_rdata : ZERO;
        bus.dm_err    = err_q;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle-by-cycle vector table plus a
// hand-written sequence around asynchronous reset.
module tb_mem_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mem_arbiter_if #(.XLEN(32)) bus ();

    mem_arbiter #(.XLEN(32), .STARVE_MAX(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ifr;
        logic [31:0] ifa;
        logic        dmr;
        logic        we;
        logic [31:0] dma;
        logic [31:0] wd;
        logic [31:0] mrd;
        logic        ifg;
        logic        dmg;
        logic        en;
        logic        mwe;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic        ifv;
        logic [31:0] ifd;
        logic        dmv;
        logic [31:0] dmd;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic [31:0] ifr, ifa, dmr, we, dma, wd, mrd,
        input logic [31:0] ifg, dmg, en, mwe, maddr, mwd,
        input logic [31:0] ifv, ifd, dmv, dmd, err);
        vec_t v;
        v.ifr = ifr[0]; v.ifa = ifa; v.dmr = dmr[0]; v.we = we[0];
        v.dma = dma; v.wd = wd; v.mrd = mrd;
        v.ifg = ifg[0]; v.dmg = dmg[0]; v.en = en[0]; v.mwe = mwe[0];
        v.maddr = maddr; v.mwd = mwd;
        v.ifv = ifv[0]; v.ifd = ifd; v.dmv = dmv[0]; v.dmd = dmd; v.err = err[0];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.if_req    = v.ifr;
        bus.if_addr   = v.ifa;
        bus.dm_req    = v.dmr;
        bus.dm_we     = v.we;
        bus.dm_addr   = v.dma;
        bus.dm_wdata  = v.wd;
        bus.mem_rdata = v.mrd;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".if_gnt"},    32'(bus.if_gnt),    32'd0);
        chk({tag, ".dm_gnt"},    32'(bus.dm_gnt),    32'd0);
        chk({tag, ".if_rvalid"}, 32'(bus.if_rvalid), 32'd0);
        chk({tag, ".dm_rvalid"}, 32'(bus.dm_rvalid), 32'd0);
        chk({tag, ".dm_err"},    32'(bus.dm_err),    32'd0);
        chk({tag, ".mem_en"},    32'(bus.mem_en),    32'd0);
        chk({tag, ".mem_we"},    32'(bus.mem_we),    32'd0);
    endtask

    initial begin
        vec_t z;
        checks   = 0;
        failures = 0;
        z = mk(0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0);
        drive(z);
        reset = 1'b0;

        // Idle, single fetch, fetch return
        vecs.push_back(mk(0,0,0,0,0,0,'h1111,            0,0,0,0,0,0, 0,0,0,0,0));
        vecs.push_back(mk(1,'h10,0,0,0,0,0,              1,0,1,0,'h10,0, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,'hDEADBEEF,        0,0,0,0,0,0, 1,'hDEADBEEF,0,0,0));
        // Data beats fetch, then fetch follows once data drops
        vecs.push_back(mk(1,'h20,1,0,'h100,0,0,          0,1,1,0,'h100,0, 0,0,0,0,0));
        vecs.push_back(mk(1,'h20,0,0,0,0,'hCAFEF00D,     1,0,1,0,'h20,0, 0,0,1,'hCAFEF00D,0));
        vecs.push_back(mk(0,0,0,0,0,0,'h12345678,        0,0,0,0,0,0, 1,'h12345678,0,0,0));
        // Both held for 8 cycles: DM DM DM IF DM DM DM IF
        vecs.push_back(mk(1,'h40,1,0,'h200,0,'hA0,       0,1,1,0,'h200,0, 0,0,0,0,0));
        vecs.push_back(mk(1,'h40,1,0,'h200,0,'hA1,       0,1,1,0,'h200,0, 0,0,1,'hA1,0));
        vecs.push_back(mk(1,'h40,1,0,'h200,0,'hA2,       0,1,1,0,'h200,0, 0,0,1,'hA2,0));
        vecs.push_back(mk(1,'h40,1,0,'h200,0,'hA3,       1,0,1,0,'h40,0, 0,0,1,'hA3,0));
        vecs.push_back(mk(1,'h40,1,0,'h200,0,'hA4,       0,1,1,0,'h200,0, 1,'hA4,0,0,0));
        vecs.push_back(mk(1,'h40,1,0,'h200,0,'hA5,       0,1,1,0,'h200,0, 0,0,1,'hA5,0));
        vecs.push_back(mk(1,'h40,1,0,'h200,0,'hA6,       0,1,1,0,'h200,0, 0,0,1,'hA6,0));
        vecs.push_back(mk(1,'h40,1,0,'h200,0,'hA7,       1,0,1,0,'h40,0, 0,0,1,'hA7,0));
        // Aligned store: granted, no read return afterwards
        vecs.push_back(mk(0,0,1,1,'h104,'h55AA55AA,'hB0, 0,1,1,1,'h104,'h55AA55AA, 1,'hB0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,'hB1,              0,0,0,0,0,0, 0,0,0,0,0));
        // Misaligned store with concurrent fetch: fetch wins, error next cycle
        vecs.push_back(mk(1,'h30,1,1,'h102,'h77,0,       1,0,1,0,'h30,0, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,'hC0,              0,0,0,0,0,0, 1,'hC0,0,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,'hC1,              0,0,0,0,0,0, 0,0,0,0,0));
        // Counter clears when fetch request drops
        vecs.push_back(mk(1,'h50,1,0,'h300,0,0,          0,1,1,0,'h300,0, 0,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,'h304,0,'hD0,          0,1,1,0,'h304,0, 0,0,1,'hD0,0));
        vecs.push_back(mk(1,'h50,1,0,'h308,0,'hD1,       0,1,1,0,'h308,0, 0,0,1,'hD1,0));
        vecs.push_back(mk(1,'h50,1,0,'h308,0,'hD2,       0,1,1,0,'h308,0, 0,0,1,'hD2,0));
        vecs.push_back(mk(1,'h50,1,0,'h308,0,'hD3,       0,1,1,0,'h308,0, 0,0,1,'hD3,0));
        vecs.push_back(mk(1,'h50,1,0,'h308,0,'hD4,       1,0,1,0,'h50,0, 0,0,1,'hD4,0));
        vecs.push_back(mk(0,0,0,0,0,0,'hD5,              0,0,0,0,0,0, 1,'hD5,0,0,0));
        // Misaligned load alone: nothing granted, error pulse, no return
        vecs.push_back(mk(0,0,1,0,'h201,0,'hE1,          0,0,0,0,0,0, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,'hE2,              0,0,0,0,0,0, 0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,'hE3,              0,0,0,0,0,0, 0,0,0,0,0));

        // Requests present during reset must not be granted
        repeat (2) @(posedge clk);
        #1 bus.if_req = 1'b1; bus.dm_req = 1'b1; bus.dm_addr = 32'h100;
        #1 chk_idle_outputs("reset_hold");
        drive(z);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1 drive(vecs[i]);
            @(negedge clk);
            chk($sformatf("v%0d.if_gnt", i),    32'(bus.if_gnt),    32'(vecs[i].ifg));
            chk($sformatf("v%0d.dm_gnt", i),    32'(bus.dm_gnt),    32'(vecs[i].dmg));
            chk($sformatf("v%0d.mem_en", i),    32'(bus.mem_en),    32'(vecs[i].en));
            chk($sformatf("v%0d.mem_we", i),    32'(bus.mem_we),    32'(vecs[i].mwe));
            chk($sformatf("v%0d.mem_addr", i),  bus.mem_addr,       vecs[i].maddr);
            chk($sformatf("v%0d.mem_wdata", i), bus.mem_wdata,      vecs[i].mwd);
            chk($sformatf("v%0d.if_rvalid", i), 32'(bus.if_rvalid), 32'(vecs[i].ifv));
            chk($sformatf("v%0d.if_rdata", i),  bus.if_rdata,       vecs[i].ifd);
            chk($sformatf("v%0d.dm_rvalid", i), 32'(bus.dm_rvalid), 32'(vecs[i].dmv));
            chk($sformatf("v%0d.dm_rdata", i),  bus.dm_rdata,       vecs[i].dmd);
            chk($sformatf("v%0d.dm_err", i),    32'(bus.dm_err),    32'(vecs[i].err));
        end

        // Reset asserted mid-cycle while a data read is being granted
        @(posedge clk);
        #1 drive(z); bus.dm_req = 1'b1; bus.dm_addr = 32'h400;
        #2 chk("rst_pre.dm_gnt", 32'(bus.dm_gnt), 32'd1);
        chk("rst_pre.mem_en", 32'(bus.mem_en), 32'd1);
        #1 reset = 1'b0;
        #1 chk_idle_outputs("rst_async");
        chk("rst_async.mem_addr", bus.mem_addr, 32'd0);
        @(posedge clk);
        #1 drive(z); bus.mem_rdata = 32'hF00D;
        @(negedge clk);
        chk_idle_outputs("rst_low");
        reset = 1'b1;
        #1 chk("rel.dm_rvalid", 32'(bus.dm_rvalid), 32'd0);
        chk("rel.dm_rdata", bus.dm_rdata, 32'd0);
        // First grant right after release
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h60;
        #1 chk("rel.if_gnt", 32'(bus.if_gnt), 32'd1);
        chk("rel.mem_addr", bus.mem_addr, 32'h60);
        @(posedge clk);
        #1 drive(z); bus.mem_rdata = 32'hE0;
        @(negedge clk);
        chk("rel1.if_rvalid", 32'(bus.if_rvalid), 32'd1);
        chk("rel1.if_rdata",  bus.if_rdata,       32'hE0);
        chk("rel1.dm_rvalid", 32'(bus.dm_rvalid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rel2.if_rvalid", 32'(bus.if_rvalid), 32'd0);
        chk("rel2.if_rdata",  bus.if_rdata,       32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
